// File: rtl/sprite_fetch_pkg.sv
// Shared types and sizing helpers for the sprite fetch initiator.
package sprite_fetch_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic int sprw_f(input int spr_words);
    return $clog2(spr_words);
  endfunction

  function automatic int addrw_f(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sprite_fetch_fifo.sv
// Single-clock FIFO with count/full/empty; head word is visible combinationally.
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int CNTW  = PTRW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNTW-1:0]  o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNTW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Streams one sprite out of a registered-read ROM, checks the echoed addresses,
// and hands the words downstream through a small credit-managed FIFO.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing ROM reads while FIFO credit allows
//   DRAIN | all reads issued; waiting for the last word to be popped
module sprite_fetch
  import sprite_fetch_pkg::*;
#(
  parameter  int WIDTH      = DATA_W,
  parameter  int DEPTH      = 256,
  parameter  int SPR_WORDS  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDRW      = addrw_f(DEPTH),
  localparam int SPRW       = sprw_f(SPR_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDRW-SPRW-1:0] i_sprite_id,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDRW-1:0]      o_rom_addr,
  input  logic [ADDRW-1:0]      i_rom_addr_return,
  input  logic [WIDTH-1:0]      i_rom_data,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready
);

  localparam int ICW = SPRW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ICW-1:0] WORDS_C  = ICW'(SPR_WORDS);
  localparam logic [ICW-1:0] LAST_IDX = ICW'(SPR_WORDS - 1);
  localparam logic [FCW:0]   FIFO_LIM = FIFO_DEPTH[FCW:0];

  state_t           r_state, w_next;
  logic [ADDRW-1:0] r_rom_addr, r_exp_addr, w_base;
  logic [ICW-1:0]   r_iss_cnt, r_ret_cnt;
  logic             r_ret_v, r_err, r_done;
  logic             w_iss, w_done_nxt, w_credit, w_push, w_pop;
  logic             w_full, w_empty;
  logic [FCW-1:0]   w_count;
  logic [FCW:0]     w_occ;
  fifo_entry_t      w_wentry, w_head;

  assign w_base = ADDRW'(i_sprite_id) << SPRW;
  // Words still in flight from the ROM count against FIFO space so a push never overflows.
  assign w_occ    = {1'b0, w_count} + {{FCW{1'b0}}, r_ret_v};
  assign w_credit = !w_full && (w_occ < FIFO_LIM);
  assign w_push   = r_ret_v && (r_state != IDLE);
  assign w_pop    = !w_empty && i_out_ready;

  assign w_wentry.last = (r_ret_cnt == LAST_IDX);
  assign w_wentry.data = i_rom_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_iss      = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = FETCH;
      FETCH: begin
        w_iss = (r_iss_cnt < WORDS_C) && w_credit;
        if (w_iss && (r_iss_cnt == LAST_IDX)) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_pop && w_head.last) begin
          w_next     = IDLE;
          w_done_nxt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rom_addr <= '0;
      r_exp_addr <= '0;
      r_iss_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_ret_v    <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done  <= w_done_nxt;
      r_ret_v <= w_iss;
      if ((r_state == IDLE) && i_start) begin
        r_rom_addr <= w_base;
        r_exp_addr <= w_base;
        r_iss_cnt  <= '0;
        r_ret_cnt  <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_iss) begin
          r_rom_addr <= r_rom_addr + ADDRW'(1);
          r_iss_cnt  <= r_iss_cnt + ICW'(1);
        end
        if (w_push) begin
          r_ret_cnt  <= r_ret_cnt + ICW'(1);
          r_exp_addr <= r_exp_addr + ADDRW'(1);
          if (i_rom_addr_return != r_exp_addr) r_err <= 1'b1;
        end
      end
    end
  end

  fifo_sync #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rom_addr  = r_rom_addr;
  assign o_out_data  = w_head.data;
  assign o_out_last  = w_head.last;
  assign o_out_valid = !w_empty;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: stimulus queues expected words, a monitor checks pops.
module tb_sprite_fetch;

  typedef struct {
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] sprite_id;
  logic       busy, done, err;
  logic [7:0] rom_addr;
  logic [7:0] rom_addr_return;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_last, out_valid;
  logic       out_ready;

  logic       corrupt_en;
  logic [7:0] corrupt_addr;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  sprite_fetch dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .i_sprite_id       (sprite_id),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err),
    .o_rom_addr        (rom_addr),
    .i_rom_addr_return (rom_addr_return),
    .i_rom_data        (rom_data),
    .o_out_data        (out_data),
    .o_out_last        (out_last),
    .o_out_valid       (out_valid),
    .i_out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM: word at address a is a ^ 0xA5; echo optionally corrupted.
  always @(posedge clk) begin
    rom_data        <= rom_addr ^ 8'hA5;
    rom_addr_return <= (corrupt_en && rom_addr == corrupt_addr) ? 8'h00 : rom_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", {24'h0, out_data}, {24'h0, e.data});
        chk("out_last", {31'h0, out_last}, {31'h0, e.last});
      end
    end
  end

  // Drives start in the current cycle; returns one cycle later (cycle 1 of the fetch).
  task automatic do_start(input logic [4:0] id);
    logic [7:0] a;
    start     = 1'b1;
    sprite_id = id;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      a      = {id, 3'b000} + 8'(i);
      e.last = (i == 7);
      e.data = a ^ 8'hA5;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", {31'h0, done}, 32'h1);
  endtask

  initial begin
    int lat;
    int d0;
    int hold_bad;

    rst_n        = 1'b0;
    start        = 1'b0;
    sprite_id    = '0;
    out_ready    = 1'b0;
    corrupt_en   = 1'b0;
    corrupt_addr = '0;
    cycles(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rom_addr", {24'h0, rom_addr}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    rst_n = 1'b1;
    cycles(2);

    // Sprite 3 with free-flowing output, then sprite 31 back-to-back.
    out_ready = 1'b1;
    d0 = done_cnt;
    do_start(5'd3);
    chk("t1_rom_addr", {24'h0, rom_addr}, 32'd24);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    wait_done(1, lat);
    chk("t1_latency", lat, 32'd11);
    chk("t1_err", {31'h0, err}, 32'h0);
    chk("t1_busy_done", {31'h0, busy}, 32'h0);
    do_start(5'd31);
    chk("t3_rom_addr", {24'h0, rom_addr}, 32'd248);
    wait_done(1, lat);
    chk("t3_latency", lat, 32'd11);
    chk("t3_err", {31'h0, err}, 32'h0);
    chk("t3_rom_addr_wrap", {24'h0, rom_addr}, 32'h0);
    cycles(3);
    chk("t13_done_pulses", done_cnt - d0, 32'd2);
    chk("t13_queue_empty", exp_q.size(), 32'h0);

    // Backpressure: ready low for 20 cycles.
    out_ready = 1'b0;
    d0 = done_cnt;
    hold_bad = 0;
    do_start(5'd1);
    for (int c = 1; c < 20; c++) begin
      if (c >= 3 && (out_data !== 8'hAD || out_last !== 1'b0 || out_valid !== 1'b1)) hold_bad++;
      @(posedge clk); #1;
    end
    chk("bp_hold", hold_bad, 32'h0);
    chk("bp_rom_addr", {24'h0, rom_addr}, 32'd12);
    chk("bp_queue_len", exp_q.size(), 32'd8);
    out_ready = 1'b1;
    wait_done(20, lat);
    cycles(3);
    chk("bp_done_pulses", done_cnt - d0, 32'd1);
    chk("bp_queue_empty", exp_q.size(), 32'h0);

    // Corrupted echo on the third word of sprite 10.
    corrupt_en   = 1'b1;
    corrupt_addr = 8'd82;
    do_start(5'd10);
    cycles(3);
    chk("ce_err_before", {31'h0, err}, 32'h0);
    cycles(1);
    chk("ce_err_after", {31'h0, err}, 32'h1);
    wait_done(5, lat);
    chk("ce_err_sticky", {31'h0, err}, 32'h1);
    corrupt_en = 1'b0;
    cycles(2);
    chk("ce_queue_empty", exp_q.size(), 32'h0);

    // Reset after three issues.
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start(5'd9);
    chk("rs_err_cleared", {31'h0, err}, 32'h0);
    cycles(3);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk("rs_busy", {31'h0, busy}, 32'h0);
    chk("rs_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rs_done", {31'h0, done}, 32'h0);
    exp_q.delete();
    cycles(2);
    chk("rs_no_done", done_cnt - d0, 32'h0);
    out_ready = 1'b1;
    do_start(5'd5);
    chk("rs_rom_addr", {24'h0, rom_addr}, 32'd40);
    wait_done(1, lat);
    chk("rs_latency", lat, 32'd11);
    chk("rs_err", {31'h0, err}, 32'h0);
    cycles(2);

    // Start pulse while busy must be ignored.
    d0 = done_cnt;
    do_start(5'd2);
    cycles(2);
    start     = 1'b1;
    sprite_id = 5'd7;
    cycles(1);
    start = 1'b0;
    wait_done(4, lat);
    chk("sb_latency", lat, 32'd11);
    chk("sb_rom_addr", {24'h0, rom_addr}, 32'd24);
    cycles(4);
    chk("sb_done_pulses", done_cnt - d0, 32'd1);
    chk("sb_busy", {31'h0, busy}, 32'h0);
    chk("sb_queue_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Initiator side of the registered-read sprite ROM (1-cycle latency, echoes the sampled address back as addr_return).
- On `start`, streams all words of one sprite out of the ROM and checks every returned word against the expected address.
- Buffers the words in a small FIFO and presents them downstream on a valid/ready stream, ending with a last marker.
- Sits between the sprite ROM and the renderer / line-buffer logic.

Parameters:
- WIDTH, 8: ROM data word width; also the output data width.
- DEPTH, 256: ROM depth in words; ADDRW = $clog2(DEPTH).
- SPR_WORDS, 8: words per sprite. Must be a power of two and ≤ DEPTH; SPRW = $clog2(SPR_WORDS).
- FIFO_DEPTH, 4: output buffer depth. Must be a power of two and ≥ 2.

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: single-cycle request. Sampled only in IDLE.
- sprite_id, in, ADDRW-SPRW: sprite index. Base address = sprite_id * SPR_WORDS.
- busy, out, 1: high whenever the FSM is not in IDLE.
- done, out, 1: one-cycle pulse after the last word is accepted downstream.
- err, out, 1: sticky address-mismatch flag; cleared by an accepted start.
- rom_addr, out, ADDRW: registered address to the ROM.
- rom_addr_return, in, ADDRW: address echoed back by the ROM.
- rom_data, in, WIDTH: ROM read data.
- out_data, out, WIDTH: FIFO head word.
- out_last, out, 1: high when the FIFO head is word SPR_WORDS-1.
- out_valid, out, 1: FIFO not empty.
- out_ready, in, 1: downstream accept.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State=IDLE; busy=0, done=0, err=0.
  - rom_addr=0, all counters=0, ret_v=0.
  - FIFO flushed, so out_valid=0.
  - Applies mid-operation too; in-flight ROM returns are discarded.
- Issue and return timing:
  - `iss` is a combinational signal: the ROM samples rom_addr at the end of a cycle in which iss=1.
  - ret_v is iss registered one cycle. While ret_v=1, rom_data and rom_addr_return belong to that issue.
- Credit rule:
  - iss requires fifo_count + ret_v < FIFO_DEPTH.
  - A pop in the same cycle is ignored for credit (conservative); this guarantees no push ever finds the FIFO full.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - On start=1: rom_addr<=sprite_id<<SPRW, exp_addr<=same value, iss_cnt<=0, ret_cnt<=0, err<=0, next state FETCH.
- FETCH:
  - iss = (iss_cnt < SPR_WORDS) && credit.
  - On iss: rom_addr<=rom_addr+1 and iss_cnt++.
  - When an issue makes iss_cnt reach SPR_WORDS, next state is DRAIN. rom_addr then holds base+SPR_WORDS; it wraps modulo DEPTH for the top sprite and is not sampled.
- Returns (any state except IDLE):
  - On ret_v: push {ret_cnt==SPR_WORDS-1, rom_data} into the FIFO, then ret_cnt++ and exp_addr++.
  - If rom_addr_return != exp_addr, set err=1. The word is still pushed.
- DRAIN:
  - Stays until a pop occurs (out_valid && out_ready) with out_last=1.
  - Then done=1 for exactly one cycle and the FSM returns to IDLE. A back-to-back start is accepted on the following cycle.
- start is ignored while busy=1.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
- out_ready=0 holds out_data and out_last stable while out_valid=1.
- Minimum start-to-done latency with out_ready held at 1: SPR_WORDS+3 cycles.
- done can never fire before all SPR_WORDS words have been popped.

Decomposition:
- Package sprite_fetch_pkg:
  - state enum (IDLE, FETCH, DRAIN);
  - FIFO entry struct {last, data};
  - SPRW and ADDRW helper functions.
- One sub-module, fifo_sync:
  - parameters: width, depth;
  - single clock, synchronous active-low reset;
  - push/pop interface with count, full and empty outputs.

Test Plan:
- Fetch with out_ready=1: sprite_id=3, ROM word i = i ^ 0xA5 -> rom_addr sequence 24..31; out words are those at addrs 24..31 in order; out_last only on the 8th; done 11 cycles after start; err=0.
- Backpressure: out_ready=0 for the first 20 cycles after start -> exactly 4 words issued then iss stalls; out_data held stable; after release, all 8 words arrive in order and done pulses once.
- Top sprite wrap: sprite_id=31, DEPTH=256 -> addrs 248..255 issued; no issue of address 0; err=0.
- Corrupt echo: ROM model returns rom_addr_return=0 on the 3rd word -> err=1 from the next cycle until the next start; all 8 words still delivered.
- Reset mid-fetch: rst_n=0 for 1 cycle after 3 words are issued -> next cycle busy=0, out_valid=0, no done; a fresh start with sprite_id=5 fetches addrs 40..47 cleanly.
- start while busy: pulse start with sprite_id=7 during FETCH of sprite 2 -> ignored; only addrs 16..23 are returned and exactly one done pulse occurs.
